// File: rtl/sweep_sequencer.sv
// rtl/sweep_sequencer.sv - ping-pong servo sweep with settle, measure request and pronto/timeout wait
// Optional feature macro: SWEEP_TIMEOUT_EN (timeout counter and timeout output; tied off when undefined)
module sweep_sequencer #(
    parameter int SETTLE_CYCLES  = 25_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto,
    output logic       mensurar,
    output logic [2:0] largura,
    output logic       fim_posicao,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Counters hold 0..N-1; a one-cycle parameter still needs one bit.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        ESPERA  = 3'd1,
        MEDE    = 3'd2,
        AGUARDA = 3'd3,
        PROXIMO = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic            dir_up;
    logic [2:0]      largura_next;
    logic            dir_up_next;

    // Both timing parameters must describe at least one cycle.
    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sweep_sequencer: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] timeout_cnt;
    logic          timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Next sweep position: endpoints turn the direction around without repeating themselves.
    always_comb begin
        largura_next = largura;
        dir_up_next  = dir_up;
        if (dir_up) begin
            if (largura == 3'd7) begin
                largura_next = 3'd6;
                dir_up_next  = 1'b0;
            end else begin
                largura_next = largura + 3'd1;
            end
        end else begin
            if (largura == 3'd0) begin
                largura_next = 3'd1;
                dir_up_next  = 1'b1;
            end else begin
                largura_next = largura - 3'd1;
            end
        end
    end

    // Sequencer FSM; largura moves on the edge that enters PROXIMO so it lines up with fim_posicao.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INICIAL;
            settle_cnt <= '0;
            dir_up     <= 1'b1;
            largura    <= 3'd0;
`ifdef SWEEP_TIMEOUT_EN
            timeout_cnt <= '0;
            timeout_r   <= 1'b0;
`endif
        end else if (!ligar) begin
            // Stop: position, direction and the last timeout flag survive for the resume.
            state      <= INICIAL;
            settle_cnt <= '0;
`ifdef SWEEP_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
        end else begin
            case (state)
                INICIAL: begin
                    state      <= ESPERA;
                    settle_cnt <= '0;
                end
                ESPERA: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state      <= MEDE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEDE: begin
                    state <= AGUARDA;
`ifdef SWEEP_TIMEOUT_EN
                    timeout_cnt <= '0;
                    timeout_r   <= 1'b0;
`endif
                end
                AGUARDA: begin
                    // pronto is checked first so a same-cycle expiry never raises timeout.
                    if (pronto) begin
                        state   <= PROXIMO;
                        largura <= largura_next;
                        dir_up  <= dir_up_next;
`ifdef SWEEP_TIMEOUT_EN
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= PROXIMO;
                        largura     <= largura_next;
                        dir_up      <= dir_up_next;
                        timeout_r   <= 1'b1;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
`endif
                    end
                end
                PROXIMO: begin
                    state      <= ESPERA;
                    settle_cnt <= '0;
                end
                default: begin
                    state <= INICIAL;
                end
            endcase
        end
    end

    assign mensurar    = (state == MEDE);
    assign fim_posicao = (state == PROXIMO);
    assign db_estado   = {1'b0, state};

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb/tb_sweep_sequencer.sv - scoreboard bench for sweep_sequencer with an event-timing reference model
module tb_sweep_sequencer;

    localparam int S = 4;
    localparam int T = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       pronto = 1'b0;
    logic       mensurar;
    logic [2:0] largura;
    logic       fim_posicao;
    logic       timeout;
    logic [3:0] db_estado;

    sweep_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ligar      (ligar),
        .pronto     (pronto),
        .mensurar   (mensurar),
        .largura    (largura),
        .fim_posicao(fim_posicao),
        .timeout    (timeout),
        .db_estado  (db_estado)
    );

    // kind 0 = mensurar event, 1 = fim_posicao event, 2 = state snapshot at a given cycle
    typedef struct {
        int kind;
        int cyc;
        int lar;
        int to;
        int st;
    } ev_t;

    ev_t sb[$];
    int  dq[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    bit  done = 1'b0;
    int  idx = 0;
    int  last_to = 0;

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached by time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Sweep position after i advances from reset: triangle wave of period 14.
    function automatic int pos_code(input int i);
        int r;
        r = i % 14;
        return (r <= 7) ? r : 14 - r;
    endfunction

    task automatic push(input int kind, input int c, input int lar, input int to, input int st);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.lar  = lar;
        e.to   = to;
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Plan n positions starting now, then stop during the ESPERA after the last advance.
    task automatic run_segment(input int n, input int mode);
        int t, f, d, w, to;
        ligar = 1'b1;
        t = cyc + 1 + S;
        f = 0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                d = 3;
            end else begin
`ifdef SWEEP_TIMEOUT_EN
                if (i == 0)      d = 0;
                else if (i == 1) d = T;
                else if (i == 2) d = T + 1;
                else             d = $urandom_range(0, 12);
`else
                d = $urandom_range(1, 9);
`endif
            end
`ifdef SWEEP_TIMEOUT_EN
            if (d == 0 || d > T) begin
                w  = T;
                to = 1;
            end else begin
                w  = d;
                to = 0;
            end
`else
            w  = d;
            to = 0;
`endif
            push(0, t, pos_code(idx), 0, 0);
            push(1, t + w + 1, pos_code(idx + 1), to, 0);
            dq.push_back(d);
            idx     = idx + 1;
            last_to = to;
            f       = t + w + 1;
            t       = f + 1 + S;
        end
        push(2, f + 1, pos_code(idx), last_to, 1);
        push(2, f + 2, pos_code(idx), last_to, 0);
        push(2, f + 6, pos_code(idx), last_to, 0);
        wait_cycle(f + 1);
        ligar = 1'b0;
        wait_cycle(f + 6);
    endtask

    // Reset asserted during AGUARDA; the pronto answer then lands in INICIAL.
    task automatic reset_segment();
        int m;
        ligar = 1'b1;
        m = cyc + 1 + S;
        push(0, m, pos_code(idx), 0, 0);
        dq.push_back(2);
        wait_cycle(m + 1);
        reset   = 1'b0;
        ligar   = 1'b0;
        idx     = 0;
        last_to = 0;
        wait_cycle(m + 2);
        reset = 1'b1;
        push(2, m + 3, 0, 0, 0);
        push(2, m + 5, 0, 0, 0);
        wait_cycle(m + 5);
    endtask

    // Stimulus
    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        wait_cycle(cyc + 2);
        run_segment(23, 0);
        run_segment(10, 1);
        reset_segment();
        run_segment(3, 0);
        repeat (3) @(posedge clock);
        #1 done = 1'b1;
    end

    // Trena model: answers with pronto d cycles after each mensurar (d = 0 means never).
    initial begin
        int d;
        forever begin
            @(negedge clock);
            if (reset && mensurar) begin
                d = (dq.size() > 0) ? dq.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(posedge clock);
                    #1 pronto = 1'b1;
                    @(posedge clock);
                    #1 pronto = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event or a snapshot is due.
    initial begin
        ev_t e;
        bit  chk_to;
        chk_to = 1'b0;
        forever begin
            @(negedge clock or negedge reset);
            if (!reset) begin
                #1;
                check("rst_mensurar", mensurar, 0);
                check("rst_fim_posicao", fim_posicao, 0);
                check("rst_timeout", timeout, 0);
                check("rst_largura", largura, 0);
                check("rst_db_estado", db_estado, 0);
            end else if (done) begin
                check("scoreboard_drained", sb.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end else begin
                if (chk_to) begin
                    check("timeout_cleared_after_mede", timeout, 0);
                    chk_to = 1'b0;
                end
                while (sb.size() > 0 && sb[0].kind == 2 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    if (e.cyc == cyc) begin
                        check("snap_db_estado", db_estado, e.st);
                        check("snap_largura", largura, e.lar);
                        check("snap_timeout", timeout, e.to);
                    end else begin
                        n_vec = n_vec + 1;
                        n_err = n_err + 1;
                        $display("FAIL snapshot_skipped: due cycle %0d now %0d", e.cyc, cyc);
                    end
                end
                while (sb.size() > 0 && sb[0].kind != 2 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    n_vec = n_vec + 1;
                    n_err = n_err + 1;
                    $display("FAIL missed_event: kind %0d expected at cycle %0d, still pending at %0d", e.kind, e.cyc, cyc);
                end
                if (mensurar || fim_posicao) begin
                    if (sb.size() == 0 || sb[0].kind == 2 || sb[0].cyc != cyc) begin
                        n_vec = n_vec + 1;
                        n_err = n_err + 1;
                        $display("FAIL unexpected_event: mensurar=%0b fim_posicao=%0b at cycle %0d", mensurar, fim_posicao, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind_fim", fim_posicao, (e.kind == 1) ? 1 : 0);
                        check("event_kind_mensurar", mensurar, (e.kind == 0) ? 1 : 0);
                        check("event_largura", largura, e.lar);
                        if (e.kind == 1) check("event_timeout", timeout, e.to);
                    end
                    if (mensurar) chk_to = 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Servo sweep and measurement sequencer for the sonar-radar build, sitting directly upstream of the trena measurement core and the PWM servo driver. It steps the servo position (`largura`) through a ping-pong sweep, waits a settle time at each position, fires one measurement request (`mensurar`) and waits for the trena's `pronto` before advancing. It replaces the free-running measure timer and the position counter that are currently wired in the top level.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 25_000_000: servo settle time per position, in clock cycles (≥1).
- `TIMEOUT_CYCLES`, default 50_000_000: maximum wait for `pronto` after a request (≥1).

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (`reset`=0 resets).
- `ligar`  in  1  level enable; sweep runs while high.
- `pronto`  in  1  measurement-complete pulse from the trena control unit.
- `mensurar`  out  1  one-cycle measurement request to the trena.
- `largura`  out  3  servo position code to the PWM driver.
- `fim_posicao`  out  1  one-cycle pulse when a position completes (pronto or timeout).
- `timeout`  out  1  set when the last request timed out.
- `db_estado`  out  4  current state code.

## Operation
States and codes:
- INICIAL (0)
- ESPERA (1)
- MEDE (2)
- AGUARDA (3)
- PROXIMO (4)

Transitions:
- INICIAL → ESPERA when `ligar`=1.
- ESPERA: the settle counter runs. After exactly `SETTLE_CYCLES` cycles in ESPERA → MEDE.
- MEDE: `mensurar`=1 for this single cycle, `timeout` cleared, timeout counter zeroed → AGUARDA.
- AGUARDA: when `pronto`=1 → PROXIMO. When the timeout counter reaches `TIMEOUT_CYCLES` → PROXIMO with `timeout` set. If both occur in the same cycle, `pronto` wins and `timeout` stays 0.
- PROXIMO (1 cycle): `fim_posicao`=1, `largura` advances → ESPERA.

Sweep order:
- Up direction: `largura`+1. At 7 the direction flips to down.
- Down direction: `largura`−1. At 0 the direction flips to up.
- Endpoints are never repeated: 0,1,…,7,6,…,1,0,1,…

Stop and pulse handling:
- `ligar`=0 in any state → INICIAL on the next edge.
- On stop, the settle and timeout counters are zeroed. `largura`, direction and `timeout` are held.
- Re-enable resumes ESPERA at the held position.
- `pronto` outside AGUARDA is ignored.

Counters are sized by `$clog2` of their parameter; no wrap occurs because the counters are zeroed on every state entry.

## Timing
Reset values:
- Outputs: `mensurar`=0, `fim_posicao`=0, `timeout`=0, `largura`=0, `db_estado`=0.
- Internal: direction=up, counters=0, state INICIAL.
- Reset mid-sweep aborts immediately to these values.

Cycle-level timing:
- `ligar` sampled high at edge k: ESPERA from k+1; `mensurar` high during cycle k+1+`SETTLE_CYCLES`.
- `pronto` sampled at edge j in AGUARDA: `fim_posicao` and the new `largura` both appear in cycle j+1 (PROXIMO). `largura` is registered and changes only on the PROXIMO edge.
- Per-position period = `SETTLE_CYCLES` + 1 (MEDE) + wait + 1 (PROXIMO).
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Configuration
- `SWEEP_TIMEOUT_EN` defined: timeout counter and `timeout` output are implemented as described.
- `SWEEP_TIMEOUT_EN` undefined: no timeout counter. AGUARDA exits only on `pronto` (waits indefinitely), `timeout` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
Bench parameters: `SETTLE_CYCLES`=4, `TIMEOUT_CYCLES`=10; pronto model answers 3 cycles after `mensurar`.
- Reset then `ligar`=1 → `mensurar` pulses exactly 5 cycles after `ligar` sampled, width 1; `largura`=0.
- Continuous run over 16 positions → `largura` sequence 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; one `fim_posicao` per position; period 4+1+3+1 cycles.
- Pronto model disabled (macro on) → after 10 cycles in AGUARDA, `timeout`=1, `fim_posicao` pulses, `largura` advances; next MEDE clears `timeout`.
- `pronto` and timeout expiry in the same cycle → `timeout` stays 0, single advance.
- `ligar` dropped during ESPERA at `largura`=5, direction down → `db_estado`=0 next cycle, `largura` holds 5. Re-raise → next advance goes to 4.
- `reset`=0 pulse mid-AGUARDA → all outputs 0 and state INICIAL immediately, without waiting for a clock edge; a stray `pronto` in INICIAL has no effect.
